// File: rtl/mdu_defs.sv
// Shared MDU definitions: op encodings, default latencies, FSM state.
// Imported by mdu_unit and by control decode.
`timescale 1ns/1ps
package mdu_defs;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5,
        MDU_MADD  = 3'd6,
        MDU_MSUB  = 3'd7
    } mdu_op_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    function automatic logic [31:0] neg_if(input logic [31:0] v,
                                           input logic        n);
        return n ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/mdu_unit.sv
// Multiply/divide unit for the E stage; owns architectural HI/LO.
// Ports: clk, reset (sync, active-high), start, op[2:0], a, b in;
//        busy, hi_o, lo_o out.
// Optional: define MDU_MADD_EN to build MADD/MSUB (ops 6/7).
`timescale 1ns/1ps
module mdu_unit
    import mdu_defs::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam logic [4:0] MULT_LD = 5'(MULT_CYCLES - 1);
    localparam logic [4:0] DIV_LD  = 5'(DIV_CYCLES - 1);

    mdu_state_e  state_q;
    logic [4:0]  cnt_q;
    logic [63:0] pend_q;
    logic        pend_ok_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic        launch_d;
    logic [4:0]  cnt_d;
    logic [63:0] pend_d;
    logic        pend_ok_d;
    logic        wr_hi_d;
    logic        wr_lo_d;

    logic [63:0] mul_s;
    logic [63:0] mul_u;
    logic        b_zero;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] du_div;
    logic [31:0] ds_div;
    logic [31:0] qu;
    logic [31:0] ru;
    logic [31:0] qm;
    logic [31:0] rm;
    logic [31:0] qs;
    logic [31:0] rs;

    // Low 64 bits of the product of sign-extended operands equal
    // the signed 32x32 product.
    assign mul_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign mul_u = {32'd0, a} * {32'd0, b};

    // Signed divide on magnitudes avoids INT_MIN / -1 overflow:
    // |0x80000000| is still 0x80000000 as an unsigned value.
    assign b_zero = (b == 32'd0);
    assign a_neg  = a[31];
    assign b_neg  = b[31];
    assign a_mag  = neg_if(a, a_neg);
    assign b_mag  = neg_if(b, b_neg);
    assign du_div = b_zero ? 32'd1 : b;
    assign ds_div = b_zero ? 32'd1 : b_mag;
    assign qu     = a / du_div;
    assign ru     = a % du_div;
    assign qm     = a_mag / ds_div;
    assign rm     = a_mag % ds_div;
    assign qs     = neg_if(qm, a_neg ^ b_neg);
    assign rs     = neg_if(rm, a_neg);

    always_comb begin
        launch_d  = 1'b0;
        cnt_d     = 5'd0;
        pend_d    = 64'd0;
        pend_ok_d = 1'b0;
        wr_hi_d   = 1'b0;
        wr_lo_d   = 1'b0;
        case (mdu_op_e'(op))
            MDU_MULT: begin
                launch_d  = 1'b1;
                cnt_d     = MULT_LD;
                pend_d    = mul_s;
                pend_ok_d = 1'b1;
            end
            MDU_MULTU: begin
                launch_d  = 1'b1;
                cnt_d     = MULT_LD;
                pend_d    = mul_u;
                pend_ok_d = 1'b1;
            end
            MDU_DIV: begin
                launch_d  = 1'b1;
                cnt_d     = DIV_LD;
                pend_d    = {rs, qs};
                pend_ok_d = !b_zero;
            end
            MDU_DIVU: begin
                launch_d  = 1'b1;
                cnt_d     = DIV_LD;
                pend_d    = {ru, qu};
                pend_ok_d = !b_zero;
            end
            MDU_MTHI: wr_hi_d = 1'b1;
            MDU_MTLO: wr_lo_d = 1'b1;
`ifdef MDU_MADD_EN
            // Accumulator is the HI/LO value at accept, mod 2^64.
            MDU_MADD: begin
                launch_d  = 1'b1;
                cnt_d     = MULT_LD;
                pend_d    = {hi_q, lo_q} + mul_s;
                pend_ok_d = 1'b1;
            end
            MDU_MSUB: begin
                launch_d  = 1'b1;
                cnt_d     = MULT_LD;
                pend_d    = {hi_q, lo_q} - mul_s;
                pend_ok_d = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign busy = (cnt_q != 5'd0) | (state_q == ST_RUN);
    assign hi_o = hi_q;
    assign lo_o = lo_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 5'd0;
            pend_q    <= 64'd0;
            pend_ok_q <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else if (busy) begin
            // Starts arriving while busy are dropped here.
            if (cnt_q != 5'd0) begin
                cnt_q <= cnt_q - 5'd1;
            end else begin
                state_q <= ST_IDLE;
                if (pend_ok_q) begin
                    hi_q <= pend_q[63:32];
                    lo_q <= pend_q[31:0];
                end
            end
        end else if (start) begin
            if (launch_d) begin
                state_q   <= ST_RUN;
                cnt_q     <= cnt_d;
                pend_q    <= pend_d;
                pend_ok_q <= pend_ok_d;
            end
            if (wr_hi_d) begin
                hi_q <= a;
            end
            if (wr_lo_d) begin
                lo_q <= a;
            end
        end
    end

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit with an expected-result queue.
// Define MDU_MADD_EN on both bench and RTL to check MADD/MSUB.
`timescale 1ns/1ps
module tb_mdu_unit;
    import mdu_defs::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    mdu_unit dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .hi_o  (hi_o),
        .lo_o  (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns at T+1 (+1ns), i.e. inside the first busy cycle.
    task automatic issue(input logic [2:0] o,
                         input logic [31:0] x,
                         input logic [31:0] y);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(output int n, output bit to);
        n  = 0;
        to = 1'b0;
        while (busy) begin
            n++;
            if (n > 64) begin
                to = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        start = 1'b0;
        op    = 3'd0;
        a     = 32'd0;
        b     = 32'd0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || hi_o !== 32'd0 || lo_o !== 32'd0) begin
            errors++;
            $display("FAIL reset: busy=%b hi=%h lo=%h want 0/0/0",
                     busy, hi_o, lo_o);
        end
    endtask

    task automatic test_mthi();
        int n;
        bit to;
        issue(MDU_MTHI, 32'h12345678, 32'd0);
        wait_idle(n, to);
        checks++;
        if (n !== 0 || hi_o !== 32'h12345678 || lo_o !== 32'd0) begin
            errors++;
            $display("FAIL mthi: busy_cyc=%0d hi=%h lo=%h want 0 12345678 0",
                     n, hi_o, lo_o);
        end
    endtask

    task automatic test_mult();
        logic [2:0]  ops [4];
        logic [31:0] xa [4];
        logic [31:0] xb [4];
        logic [63:0] ex [4];
        ops = '{MDU_MULT, MDU_MULTU, MDU_MULT, MDU_MULTU};
        xa  = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'h80000000, 32'hFFFFFFFF};
        xb  = '{32'd3, 32'd3, 32'h80000000, 32'hFFFFFFFF};
        ex  = '{64'hFFFFFFFF_FFFFFFFA, 64'h00000002_FFFFFFFA,
                64'h40000000_00000000, 64'hFFFFFFFE_00000001};
        for (int i = 0; i < 4; i++) begin
            int   n;
            bit   to;
            exp_t e;
            sb.push_back('{ex[i][63:32], ex[i][31:0], 5});
            issue(ops[i], xa[i], xb[i]);
            wait_idle(n, to);
            e = sb.pop_front();
            checks++;
            if (to || n != e.cyc) begin
                errors++;
                $display("FAIL mult%0d_busy: got %0d cycles want %0d",
                         i, n, e.cyc);
            end
            checks++;
            if (hi_o !== e.hi || lo_o !== e.lo) begin
                errors++;
                $display("FAIL mult%0d_result: got %h_%h want %h_%h",
                         i, hi_o, lo_o, e.hi, e.lo);
            end
        end
    endtask

    task automatic test_div();
        logic [2:0]  ops [4];
        logic [31:0] xa [4];
        logic [31:0] xb [4];
        logic [63:0] ex [4];
        ops = '{MDU_DIV, MDU_DIVU, MDU_DIV, MDU_DIVU};
        xa  = '{32'hFFFFFFF9, 32'd7, 32'h80000000, 32'd7};
        xb  = '{32'd2, 32'd0, 32'hFFFFFFFF, 32'd2};
        // Second row: divide by zero leaves the first row's result.
        ex  = '{64'hFFFFFFFF_FFFFFFFD, 64'hFFFFFFFF_FFFFFFFD,
                64'h00000000_80000000, 64'h00000001_00000003};
        for (int i = 0; i < 4; i++) begin
            int   n;
            bit   to;
            exp_t e;
            sb.push_back('{ex[i][63:32], ex[i][31:0], 10});
            issue(ops[i], xa[i], xb[i]);
            wait_idle(n, to);
            e = sb.pop_front();
            checks++;
            if (to || n != e.cyc) begin
                errors++;
                $display("FAIL div%0d_busy: got %0d cycles want %0d",
                         i, n, e.cyc);
            end
            checks++;
            if (hi_o !== e.hi || lo_o !== e.lo) begin
                errors++;
                $display("FAIL div%0d_result: got %h_%h want %h_%h",
                         i, hi_o, lo_o, e.hi, e.lo);
            end
        end
    endtask

    task automatic test_reset_mid();
        issue(MDU_MULT, 32'd100, 32'd100);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_busy3: got %b want 1", busy);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || hi_o !== 32'd0 || lo_o !== 32'd0) begin
            errors++;
            $display("FAIL rstmid: busy=%b hi=%h lo=%h want 0/0/0",
                     busy, hi_o, lo_o);
        end
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || lo_o !== 32'd0) begin
            errors++;
            $display("FAIL rstmid_drop: busy=%b lo=%h want 0/0", busy, lo_o);
        end
    endtask

    task automatic test_start_busy();
        int   n;
        bit   to;
        exp_t e;
        sb.push_back('{32'd0, 32'd12, 5});
        issue(MDU_MULT, 32'd3, 32'd4);
        @(negedge clk);
        start = 1'b1;
        op    = MDU_DIV;
        a     = 32'd100;
        b     = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle(n, to);
        n = n + 1;
        e = sb.pop_front();
        checks++;
        if (to || n != e.cyc) begin
            errors++;
            $display("FAIL startbusy_cyc: got %0d want %0d", n, e.cyc);
        end
        checks++;
        if (hi_o !== e.hi || lo_o !== e.lo) begin
            errors++;
            $display("FAIL startbusy_result: got %h_%h want %h_%h",
                     hi_o, lo_o, e.hi, e.lo);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL startbusy_idle: busy=%b want 0", busy);
        end
    endtask

    task automatic test_madd();
        issue(MDU_MTHI, 32'd0, 32'd0);
        issue(MDU_MTLO, 32'hFFFFFFFF, 32'd0);
`ifdef MDU_MADD_EN
        sb.push_back('{32'd1, 32'd0, 5});
        sb.push_back('{32'd0, 32'hFFFFFFFF, 5});
`else
        sb.push_back('{32'd0, 32'hFFFFFFFF, 0});
        sb.push_back('{32'd0, 32'hFFFFFFFF, 0});
`endif
        for (int i = 0; i < 2; i++) begin
            int   n;
            bit   to;
            exp_t e;
            issue(i == 0 ? MDU_MADD : MDU_MSUB, 32'd1, 32'd1);
            wait_idle(n, to);
            e = sb.pop_front();
            checks++;
            if (to || n != e.cyc) begin
                errors++;
                $display("FAIL madd%0d_busy: got %0d cycles want %0d",
                         i, n, e.cyc);
            end
            checks++;
            if (hi_o !== e.hi || lo_o !== e.lo) begin
                errors++;
                $display("FAIL madd%0d_result: got %h_%h want %h_%h",
                         i, hi_o, lo_o, e.hi, e.lo);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mthi();
        test_mult();
        test_div();
        test_reset_mid();
        test_start_busy();
        test_madd();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
